div_unit: RTL and testbench
===========================

DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 SHALL have port clk_i, input, 1, the single clock; all state changes on its rising edge.
REQ-002 SHALL have port n_rst_i, input, 1; reset is asynchronous and active-low.
REQ-003 SHALL have port start_i, input, 1; EX stage requests a divide; sampled only in IDLE.
REQ-004 SHALL have port op_i, input, 2; 00 DIV, 01 DIVU, 10 REM, 11 REMU (`DivOpBus`).
REQ-005 SHALL have port dividend_i, input, 32 (`RegBus`); rs1 data from the id_ex register.
REQ-006 SHALL have port divisor_i, input, 32 (`RegBus`); rs2 data from the id_ex register.
REQ-007 SHALL have port flush_i, input, 1; ctrl flush, annuls any operation.
REQ-008 SHALL have port stall_req_o, output, 1; stall request to the ctrl unit.
REQ-009 SHALL have port ready_o, output, 1; result_o valid this cycle.
REQ-010 SHALL have port result_o, output, 32 (`RegBus`); quotient or remainder per latched op.

Function
REQ-011 SHALL implement the states IDLE, CALC and DONE.
REQ-012 In IDLE with start_i=1 and flush_i=0, SHALL latch op, operand magnitudes and result signs; a normal case goes to CALC, a special case goes to DONE.
REQ-013 Special cases SHALL be: divisor=0 gives quotient 0xFFFFFFFF and remainder = dividend; signed 0x80000000/0xFFFFFFFF gives quotient 0x80000000 and remainder 0.
REQ-014 CALC SHALL run exactly 32 restoring radix-2 iterations on a 6-bit counter (0..31), one quotient bit per cycle, with a 33-bit partial-remainder subtract, then go to DONE.
REQ-015 Signed ops SHALL divide magnitudes; the quotient is negated if the operand signs differ; the remainder takes the dividend sign.
REQ-016 DONE SHALL drive ready_o=1 with the final result for exactly one cycle, then return unconditionally to IDLE; start_i is ignored in DONE.
REQ-017 Latency SHALL be: start to ready = 34 cycles for normal ops, 1 cycle for special cases.
REQ-018 stall_req_o SHALL be combinational = (IDLE & start_i & ~flush_i) | CALC; it SHALL be 0 in DONE so the pipeline advances with the result.
REQ-019 result_o SHALL be 0 whenever ready_o=0.
REQ-020 flush_i=1 in any state SHALL force IDLE next cycle, with ready_o=0 and counter cleared; flush wins over a simultaneous start_i.
REQ-021 start_i held high in the IDLE cycle after DONE SHALL start a new, independent operation (back-to-back divides).
REQ-022 Operands SHALL be latched at start; later changes to dividend_i or divisor_i SHALL NOT affect the result.

Reset
REQ-023 On n_rst_i=0, SHALL asynchronously set state=IDLE and clear counter, operands and partial remainder; outputs stall_req_o=0, ready_o=0, result_o=`ZeroWord`.
REQ-024 Reset asserted mid-CALC SHALL abort the operation with no ready_o pulse after release.

Structure
REQ-025 DIV/DIVU/REM/REMU codes, `DivOpBus`, the state encodings and the iteration count (32) SHALL live in defines.v.
REQ-026 Shall be a single module with no sub-modules; the 33-bit subtractor and sign fix-up are inline logic.

Verification
REQ-027 DIVU 100/7 -> ready_o at cycle 34, result 14; stall_req_o high for cycles 0..33.
REQ-028 REM 0xFFFFFFF9 (-7) / 2 -> result 0xFFFFFFFF (-1); DIV of the same operands -> 0xFFFFFFFD (-3).
REQ-029 DIV 5/0 -> ready_o after 1 cycle, result 0xFFFFFFFF; REMU 5/0 -> result 5.
REQ-030 DIV 0x80000000 / 0xFFFFFFFF -> result 0x80000000 in 1 cycle; REM of the same operands -> 0.
REQ-031 flush_i at CALC iteration 10 -> IDLE next cycle, no ready_o pulse; a new DIVU 9/3 then returns 3 after 34 cycles.
REQ-032 n_rst_i low at iteration 20 -> all outputs 0 immediately; after release, ready_o stays 0 until a new start_i.

Source files
------------

// File: rtl/div_unit_pkg.sv
// Shared definitions for the iterative 32-bit divider: op codes, FSM states,
// widths and the iteration count.
package div_unit_pkg;

    localparam int unsigned REG_W     = 32;
    localparam int unsigned DIV_ITERS = 32;
    localparam int unsigned CNT_W     = 6;

    localparam logic [REG_W-1:0] ZERO_WORD = '0;
    localparam logic [REG_W-1:0] ALL_ONES  = '1;
    localparam logic [REG_W-1:0] INT_MIN   = 32'h8000_0000;

    typedef enum logic [1:0] {
        OP_DIV  = 2'b00,
        OP_DIVU = 2'b01,
        OP_REM  = 2'b10,
        OP_REMU = 2'b11
    } div_op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_CALC = 2'b01,
        S_DONE = 2'b10
    } div_state_e;

    function automatic logic op_is_signed(input div_op_e op);
        return (op == OP_DIV) || (op == OP_REM);
    endfunction

    function automatic logic op_is_rem(input div_op_e op);
        return (op == OP_REM) || (op == OP_REMU);
    endfunction

endpackage

// File: rtl/div_unit.sv
// Multi-cycle restoring radix-2 divider for the EX stage: DIV/DIVU/REM/REMU
// with a one-cycle ready pulse and a stall request while busy.
module div_unit
    import div_unit_pkg::*;
(
    input  logic        clk_i,
    input  logic        n_rst_i,
    input  logic        start_i,
    input  logic [1:0]  op_i,
    input  logic [31:0] dividend_i,
    input  logic [31:0] divisor_i,
    input  logic        flush_i,
    output logic        stall_req_o,
    output logic        ready_o,
    output logic [31:0] result_o
);

    div_state_e       state, state_next;
    logic [CNT_W-1:0] cnt;
    div_op_e          op_q;
    logic             neg_q, neg_r;
    logic [REG_W-1:0] quot, rem, dvsr, result_q;

    div_op_e          op_in;
    logic             sgn_in;
    logic [REG_W-1:0] mag_a, mag_b;
    logic             div_zero, overflow, special;
    logic [REG_W-1:0] special_res;
    logic [REG_W:0]   trial;
    logic [REG_W-1:0] q_fix, r_fix;
    logic             iter_done;

    assign op_in  = div_op_e'(op_i);
    assign sgn_in = op_is_signed(op_in);
    assign mag_a  = (sgn_in && dividend_i[31]) ? (ZERO_WORD - dividend_i) : dividend_i;
    assign mag_b  = (sgn_in && divisor_i[31])  ? (ZERO_WORD - divisor_i)  : divisor_i;

    assign div_zero = (divisor_i == ZERO_WORD);
    assign overflow = sgn_in && (dividend_i == INT_MIN) && (divisor_i == ALL_ONES);
    assign special  = div_zero || overflow;

    // Divide-by-zero keeps the raw dividend as remainder; overflow leaves remainder 0.
    always_comb begin
        special_res = ZERO_WORD;
        if (div_zero)
            special_res = op_is_rem(op_in) ? dividend_i : ALL_ONES;
        else if (overflow)
            special_res = op_is_rem(op_in) ? ZERO_WORD : INT_MIN;
    end

    assign trial     = {rem, quot[REG_W-1]} - {1'b0, dvsr};
    assign q_fix     = neg_q ? (ZERO_WORD - quot) : quot;
    assign r_fix     = neg_r ? (ZERO_WORD - rem)  : rem;
    assign iter_done = (cnt == CNT_W'(DIV_ITERS));

    always_ff @(posedge clk_i or negedge n_rst_i) begin
        if (!n_rst_i)
            state <= S_IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: if (start_i && !flush_i) state_next = special ? S_DONE : S_CALC;
            S_CALC: if (iter_done)           state_next = S_DONE;
            S_DONE:                          state_next = S_IDLE;
            default:                         state_next = S_IDLE;
        endcase
        if (flush_i)
            state_next = S_IDLE;
    end

    // CALC spends cnt 0..31 on iterations and cnt==32 on the sign fix-up,
    // which gives the 34-cycle start-to-ready latency.
    always_ff @(posedge clk_i or negedge n_rst_i) begin
        if (!n_rst_i) begin
            cnt      <= '0;
            op_q     <= OP_DIV;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            quot     <= '0;
            rem      <= '0;
            dvsr     <= '0;
            result_q <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    cnt <= '0;
                    if (start_i && !flush_i) begin
                        op_q  <= op_in;
                        neg_q <= sgn_in && (dividend_i[31] ^ divisor_i[31]);
                        neg_r <= sgn_in && dividend_i[31];
                        quot  <= mag_a;
                        rem   <= '0;
                        dvsr  <= mag_b;
                        if (special)
                            result_q <= special_res;
                    end
                end
                S_CALC: begin
                    if (flush_i) begin
                        cnt <= '0;
                    end else if (iter_done) begin
                        cnt      <= '0;
                        result_q <= op_is_rem(op_q) ? r_fix : q_fix;
                    end else begin
                        cnt  <= cnt + 1'b1;
                        quot <= {quot[REG_W-2:0], ~trial[REG_W]};
                        rem  <= trial[REG_W] ? {rem[REG_W-2:0], quot[REG_W-1]} : trial[REG_W-1:0];
                    end
                end
                default: cnt <= '0;
            endcase
        end
    end

    assign stall_req_o = ((state == S_IDLE) && start_i && !flush_i) || (state == S_CALC);
    assign ready_o     = (state == S_DONE);
    assign result_o    = ready_o ? result_q : ZERO_WORD;

endmodule

// File: tb/tb_div_unit.sv
// Directed test of div_unit: normal and special-case ops, latency, flush,
// back-to-back starts and mid-operation reset.
module tb_div_unit;

    localparam logic [1:0] DIV  = 2'b00;
    localparam logic [1:0] DIVU = 2'b01;
    localparam logic [1:0] REM  = 2'b10;
    localparam logic [1:0] REMU = 2'b11;

    logic        clk = 1'b0;
    logic        n_rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        flush;
    logic        stall_req;
    logic        ready;
    logic [31:0] result;

    int total = 0;
    int bad   = 0;

    div_unit dut (
        .clk_i       (clk),
        .n_rst_i     (n_rst),
        .start_i     (start),
        .op_i        (op),
        .dividend_i  (dividend),
        .divisor_i   (divisor),
        .flush_i     (flush),
        .stall_req_o (stall_req),
        .ready_o     (ready),
        .result_o    (result)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Entered and left at posedge+1. Operands are scrambled after the start
    // cycle so a design that fails to latch them produces a wrong result.
    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          input int exp_lat, input logic [31:0] exp_res, input string tag);
        int   lat;
        logic stall_ok;
        op = o; dividend = a; divisor = b; start = 1'b1;
        #1;
        stall_ok = stall_req;
        lat = 0;
        while (lat < 50) begin
            @(posedge clk); #1;
            lat++;
            if (lat == 1) begin
                start = 1'b0; dividend = ~a; divisor = b ^ 32'h0000_0F0F; op = ~o;
            end
            #1;
            if (ready) break;
            stall_ok &= stall_req;
        end
        check({tag, "_lat"},   32'(lat), 32'(exp_lat));
        check({tag, "_res"},   result, exp_res);
        check({tag, "_stall"}, {31'b0, stall_ok}, 32'd1);
        check({tag, "_stall_done"}, {31'b0, stall_req}, 32'd0);
        @(posedge clk); #1;
        check({tag, "_rdy_after"}, {31'b0, ready}, 32'd0);
        check({tag, "_res_after"}, result, 32'd0);
    endtask

    task automatic expect_no_ready(input int cycles, input string tag);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk); #1;
            seen |= ready;
        end
        check(tag, {31'b0, seen}, 32'd0);
    endtask

    initial begin
        n_rst = 1'b0; start = 1'b0; flush = 1'b0;
        op = DIV; dividend = '0; divisor = '0;
        #1;
        check("rst_stall",  {31'b0, stall_req}, 32'd0);
        check("rst_ready",  {31'b0, ready},     32'd0);
        check("rst_result", result,             32'd0);
        repeat (2) @(posedge clk);
        #1 n_rst = 1'b1;
        @(posedge clk); #1;

        run_op(DIVU, 32'd100,       32'd7, 34, 32'd14,        "divu_100_7");
        run_op(REM,  32'hFFFF_FFF9, 32'd2, 34, 32'hFFFF_FFFF, "rem_m7_2");
        run_op(DIV,  32'hFFFF_FFF9, 32'd2, 34, 32'hFFFF_FFFD, "div_m7_2");
        run_op(DIV,  32'd5, 32'd0, 1, 32'hFFFF_FFFF, "div_5_0");
        run_op(REMU, 32'd5, 32'd0, 1, 32'd5,         "remu_5_0");
        run_op(REM,  32'hFFFF_FFF9, 32'd0, 1, 32'hFFFF_FFF9, "rem_m7_0");
        run_op(DIV,  32'h8000_0000, 32'hFFFF_FFFF, 1, 32'h8000_0000, "div_ovf");
        run_op(REM,  32'h8000_0000, 32'hFFFF_FFFF, 1, 32'd0,         "rem_ovf");
        run_op(DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 34, 32'd0,        "divu_big");
        run_op(DIV,  32'd7, 32'hFFFF_FFFE, 34, 32'hFFFF_FFFD, "div_7_m2");
        run_op(REM,  32'd7, 32'hFFFF_FFFE, 34, 32'd1,         "rem_7_m2");
        run_op(DIVU, 32'hFFFF_FFFF, 32'd1,  34, 32'hFFFF_FFFF, "divu_max_1");
        run_op(REMU, 32'hFFFF_FFFF, 32'h10, 34, 32'h0000_000F, "remu_max_16");

        // Back-to-back: start held through DONE launches the next op.
        op = DIV; dividend = 32'd5; divisor = 32'd0; start = 1'b1;
        @(posedge clk); #1;
        op = REMU;
        #1;
        check("b2b_first_rdy", {31'b0, ready}, 32'd1);
        check("b2b_first_res", result, 32'hFFFF_FFFF);
        @(posedge clk); #2;
        check("b2b_idle_rdy",   {31'b0, ready},     32'd0);
        check("b2b_idle_stall", {31'b0, stall_req}, 32'd1);
        @(posedge clk); #1;
        start = 1'b0;
        #1;
        check("b2b_second_rdy", {31'b0, ready}, 32'd1);
        check("b2b_second_res", result, 32'd5);
        @(posedge clk); #1;

        // Flush at CALC iteration 10.
        op = DIVU; dividend = 32'd1000; divisor = 32'd3; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) begin @(posedge clk); #1; end
        flush = 1'b1;
        #1;
        check("flush_calc_stall", {31'b0, stall_req}, 32'd1);
        @(posedge clk); #1;
        flush = 1'b0;
        #1;
        check("flush_idle_stall", {31'b0, stall_req}, 32'd0);
        check("flush_idle_rdy",   {31'b0, ready},     32'd0);
        expect_no_ready(40, "flush_no_ready");
        run_op(DIVU, 32'd9, 32'd3, 34, 32'd3, "divu_9_3_after_flush");

        // Flush beats a simultaneous start.
        op = DIVU; dividend = 32'd9; divisor = 32'd3; start = 1'b1; flush = 1'b1;
        #1;
        check("flush_start_stall", {31'b0, stall_req}, 32'd0);
        @(posedge clk); #1;
        start = 1'b0; flush = 1'b0;
        expect_no_ready(40, "flush_start_no_ready");

        // Reset at CALC iteration 20.
        op = DIVU; dividend = 32'd100; divisor = 32'd7; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (20) begin @(posedge clk); #1; end
        n_rst = 1'b0;
        #1;
        check("rst_mid_stall",  {31'b0, stall_req}, 32'd0);
        check("rst_mid_ready",  {31'b0, ready},     32'd0);
        check("rst_mid_result", result,             32'd0);
        @(posedge clk); #1;
        n_rst = 1'b1;
        expect_no_ready(40, "rst_mid_no_ready");
        run_op(DIVU, 32'd100, 32'd7, 34, 32'd14, "divu_after_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule
